player_dec: RTL and testbench

//  Inverse bit-permutation layer (P-layer) of the PRESENT 64-bit block cipher, used in the decryption datapath.

---
 rtl/present_pkg.sv | 24 ++
 rtl/player_dec.sv | 50 +++++
 tb/tb_player_dec.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/present_pkg.sv
`default_nettype none
// ============================================================================
// Module  : present_pkg
// Brief   : Shared PRESENT-64 constants, state type and P-layer index maps.
// Revision: 1.0 - initial release
// ============================================================================
package present_pkg;

    localparam int PRESENT_WIDTH = 64;

    typedef logic [PRESENT_WIDTH-1:0] present_state_t;

    // Inverse P-layer: input bit j lands on output bit inv_p_idx(j).
    function automatic int inv_p_idx(int j);
        return (j == 63) ? 63 : (4 * j) % 63;
    endfunction

    // Forward P-layer: input bit i lands on output bit fwd_p_idx(i).
    function automatic int fwd_p_idx(int i);
        return (i == 63) ? 63 : (16 * i) % 63;
    endfunction

endpackage
`default_nettype wire

// File: rtl/player_dec.sv
`default_nettype none
// ============================================================================
// Module  : player_dec
// Brief   : PRESENT inverse bit-permutation layer, combinational output plus
//           a registered copy with a valid flag for pipelined rounds.
// Revision: 1.0 - initial release
// ============================================================================
module player_dec
    import present_pkg::*;
#(
    parameter int WIDTH = PRESENT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] original,
    input  logic             in_valid,
    output logic [WIDTH-1:0] permuted,
    output logic [WIDTH-1:0] permuted_q,
    output logic             out_valid
);

    if (WIDTH != PRESENT_WIDTH) begin : g_bad_width
        $error("player_dec: WIDTH must be 64");
    end

    present_state_t w_permuted;
    present_state_t r_permuted_q;
    logic           r_out_valid;

    for (genvar j = 0; j < PRESENT_WIDTH; j++) begin : g_perm
        assign w_permuted[inv_p_idx(j)] = original[j];
    end

    // Loads every cycle; in_valid only qualifies the data downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_permuted_q <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            r_permuted_q <= w_permuted;
            r_out_valid  <= in_valid;
        end
    end

    assign permuted   = w_permuted;
    assign permuted_q = r_permuted_q;
    assign out_valid  = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_player_dec.sv
`default_nettype none
// ============================================================================
// Module  : tb_player_dec
// Brief   : Directed self-checking bench for player_dec.
// Revision: 1.0 - initial release
// ============================================================================
module tb_player_dec;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] original;
    logic [63:0] permuted;
    logic [63:0] permuted_q;
    logic        out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int NVEC = 7;
    logic [127:0] vec [0:NVEC-1];

    player_dec #(.WIDTH(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .original   (original),
        .in_valid   (in_valid),
        .permuted   (permuted),
        .permuted_q (permuted_q),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Gather form of the inverse layer: out[k] = in[16k mod 63].
    function automatic logic [63:0] model_inv(input logic [63:0] x);
        logic [63:0] y;
        for (int k = 0; k < 63; k++) y[k] = x[(16 * k) % 63];
        y[63] = x[63];
        return y;
    endfunction

    // Forward PRESENT layer: in bit i -> out bit 16i mod 63.
    function automatic logic [63:0] model_fwd(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) y[(16 * i) % 63] = x[i];
        y[63] = x[63];
        return y;
    endfunction

    initial begin
        logic [63:0] prev_exp;
        logic        prev_valid;
        logic [63:0] x;
        logic [63:0] e;
        logic [63:0] hold;

        vec[0] = {64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001};
        vec[1] = {64'h0000_0000_0000_0002, 64'h0000_0000_0000_0010};
        vec[2] = {64'h0000_0000_0001_0000, 64'h0000_0000_0000_0002};
        vec[3] = {64'h4000_0000_0000_0000, 64'h0800_0000_0000_0000};
        vec[4] = {64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        vec[5] = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vec[6] = {64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};

        reset    = 1'b1;
        in_valid = 1'b1;
        original = 64'h1234_5678_9ABC_DEF0;
        #1;
        check("reset_q", permuted_q, 64'h0);
        check("reset_valid", {63'h0, out_valid}, 64'h0);
        check("reset_comb", permuted, model_inv(64'h1234_5678_9ABC_DEF0));

        @(negedge clk);
        reset    = 1'b0;
        original = 64'h0;
        in_valid = 1'b0;
        @(posedge clk);
        prev_exp   = 64'h0;
        prev_valid = 1'b0;

        // Directed vectors: apply after posedge, check comb at negedge,
        // and check the registered copy of the previous vector at posedge.
        for (int i = 0; i < NVEC; i++) begin
            if ($isunknown(vec[i])) break;
            #1;
            check("vec_q", permuted_q, prev_exp);
            check("vec_valid", {63'h0, out_valid}, {63'h0, prev_valid});
            original = vec[i][127:64];
            in_valid = i[0];
            @(negedge clk);
            check($sformatf("vec%0d", i), permuted, vec[i][63:0]);
            prev_exp   = vec[i][63:0];
            prev_valid = i[0];
            @(posedge clk);
        end
        #1;
        check("vec_q_last", permuted_q, prev_exp);

        for (int j = 0; j < 64; j++) begin
            original = 64'd1 << j;
            e = '0;
            e[(j == 63) ? 63 : (4 * j) % 63] = 1'b1;
            @(negedge clk);
            check($sformatf("walk%0d", j), permuted, e);
        end

        for (int r = 0; r < 8; r++) begin
            x = {$urandom, $urandom};
            original = model_fwd(x);
            @(negedge clk);
            check($sformatf("roundtrip%0d", r), permuted, x);
            check($sformatf("gather%0d", r), permuted, model_inv(original));
        end

        // Asynchronous reset asserted between edges.
        @(posedge clk);
        #1;
        original = 64'hDEAD_BEEF_0000_0001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("pre_reset_q", permuted_q, model_inv(64'hDEAD_BEEF_0000_0001));
        check("pre_reset_valid", {63'h0, out_valid}, 64'h1);
        hold = permuted;
        #2;
        reset = 1'b1;
        #1;
        check("async_q", permuted_q, 64'h0);
        check("async_valid", {63'h0, out_valid}, 64'h0);
        check("async_comb", permuted, hold);
        @(posedge clk);
        #1;
        check("held_q", permuted_q, 64'h0);

        @(negedge clk);
        reset    = 1'b0;
        original = 64'h2;
        in_valid = 1'b1;
        #1;
        check("release_q_before_edge", permuted_q, 64'h0);
        @(posedge clk);
        #1;
        check("release_q", permuted_q, 64'h10);
        check("release_valid", {63'h0, out_valid}, 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
